chart_sequencer: RTL
====================

Name: chart_sequencer

Overview:
- Sequences chart playback for the 4-lane game: selects a song, walks the chart ROM address, and generates the fall tick that scrolls the lane shift registers.
- Emits one 4-bit note row per chart step, aligned to a spawn strobe, for the scoring/track datapath to inject into the top of the lanes.
- Owns play/pause/end-of-song state so the scoring datapath only reacts to strobes.

Parameters:
FALL_DIV, 100000, clk cycles per fall tick (one lane shift)
TICKS_PER_ROW, 125, fall ticks per chart row
ADDR_W, 11, chart ROM address width
ROM_LAT, 1, cycles from rom_addr change to valid rom_data (synchronous block ROM)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin the selected song from row 0
pause  in  1  one-cycle pulse: toggle PLAY/PAUSE
sw  in  2  song select; sampled only on an accepted start
rom_data0..rom_data3  in  4 each  note row from song ROMs 0..3
rom_addr  out  ADDR_W  shared chart ROM address
fall_tick  out  1  one-cycle pulse per lane shift
spawn  out  1  one-cycle pulse: spawn_notes valid, inject at lane top
spawn_notes  out  4  bit i = note in lane i
song_id  out  2  latched song selection
playing  out  1  high in LOAD/PLAY
done  out  1  high in DONE until the next start or rst

Behaviour:
- Reset: state=IDLE, rom_addr=0, fall_tick=0, spawn=0, spawn_notes=0, song_id=0, playing=0, done=0, all counters 0.
- States: IDLE, LOAD, PLAY, PAUSE, DONE.
- IDLE/DONE + start: latch song_id<=sw, rom_addr<=0, clear counters and done, enter LOAD.
- LOAD: wait ROM_LAT+1 cycles (data and mux register), then register row 0 and enter PLAY. No ticks in LOAD.
- PLAY:
  - div_cnt counts 0..FALL_DIV-1; fall_tick pulses on the cycle div_cnt wraps.
  - On each fall_tick, row_cnt increments. When row_cnt reaches TICKS_PER_ROW-1 and a tick occurs:
    - row_cnt<=0;
    - spawn=1 with spawn_notes = registered row for rom_addr;
    - rom_addr<=rom_addr+1.
  - spawn and its fall_tick occur on the same cycle. The consumer shifts first, then injects.
- Song data mux: sel_row <= rom_data[song_id], registered once. The next row is valid long before the next spawn because TICKS_PER_ROW*FALL_DIV far exceeds ROM_LAT+1.
- End of song:
  - Entered when the spawned row address equals SONG_LEN[song_id]-1.
  - After that spawn, remain in PLAY for DRAIN_TICKS further fall_ticks so the last notes reach the judge line, then enter DONE.
  - done=1, playing=0, rom_addr holds.
- rom_addr wrap: if rom_addr reaches 2^ADDR_W-1 before SONG_LEN, treat it as the end (no wrap).
- PAUSE:
  - pause in PLAY enters PAUSE; pause in PAUSE returns to PLAY.
  - div_cnt, row_cnt and rom_addr are frozen. No fall_tick or spawn.
  - playing stays 1.
  - pause in IDLE/LOAD/DONE is ignored.
- Simultaneous events:
  - start in PLAY/PAUSE restarts the song (re-latch sw, go to LOAD).
  - start has priority over pause in the same cycle.
  - rst overrides everything.
- sw changes outside an accepted start have no effect.
- All strobes are exactly one cycle wide.

Decomposition:
- Package game_pkg holds:
  - state enum;
  - SONG_LEN[0:3] (ADDR_W-bit chart lengths);
  - DRAIN_TICKS (=445, judge-line depth in ticks).
- Optional sub-module tick_divider: parameterised FALL_DIV counter with enable, producing fall_tick.

Test Plan (FALL_DIV=4, TICKS_PER_ROW=3, SONG_LEN={5,8,8,8}, DRAIN_TICKS=2):
1. Reset, then sw=0, start -> playing=1 after 1 cycle; first fall_tick 4 cycles after PLAY entry; spawn on every 3rd tick with spawn_notes = ROM0[0],[1],..; rom_addr increments by 1 per spawn.
2. Song 0 end -> after spawn of addr 4 and 2 more ticks: done=1, playing=0, no further ticks; a later start clears done and begins again at addr 0.
3. pause mid-row -> fall_tick/spawn stop, rom_addr and counters frozen; second pause resumes and the next tick arrives after exactly the remaining div count.
4. Change sw 0->1 during PLAY -> spawn_notes still from ROM0; a start then latches song_id=1 and spawns ROM1 rows from addr 0.
5. start and pause in the same cycle during PLAY -> restart wins, state LOAD; pause in IDLE -> ignored.
6. rst asserted mid-PLAY and mid-PAUSE -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/chart_sequencer_pkg.sv
// Shared types and song table for the chart playback sequencer.
package chart_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_PAUSE,
        ST_DONE
    } state_e;

    // Chart lengths in rows; each fits the 11-bit chart ROM address space.
    localparam int SONG_LEN [4] = '{1536, 1280, 1792, 2047};

    // Fall ticks needed for the last spawned row to reach the judge line.
    localparam int DRAIN_TICKS = 445;

endpackage

// File: rtl/chart_sequencer_tick_divider.sv
// Free-running clk divider that flags the cycle on which a fall tick is due.
module chart_sequencer_tick_divider #(
    parameter int FALL_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic wrap_o
);
    localparam int CW = $clog2(FALL_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(FALL_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap_o = en_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (clr_i || wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chart_sequencer.sv
// Chart playback sequencer: song select, chart ROM walk, fall tick and
// row spawn strobes, plus play/pause/end-of-song control.
module chart_sequencer
    import chart_sequencer_pkg::*;
#(
    parameter int FALL_DIV      = 100000,
    parameter int TICKS_PER_ROW = 125,
    parameter int ADDR_W        = 11,
    parameter int ROM_LAT       = 1,
    parameter int SONG_LEN_0    = SONG_LEN[0],
    parameter int SONG_LEN_1    = SONG_LEN[1],
    parameter int SONG_LEN_2    = SONG_LEN[2],
    parameter int SONG_LEN_3    = SONG_LEN[3],
    parameter int DRAIN_TICKS_P = DRAIN_TICKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic [1:0]        sw,
    input  logic [3:0]        rom_data0,
    input  logic [3:0]        rom_data1,
    input  logic [3:0]        rom_data2,
    input  logic [3:0]        rom_data3,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              fall_tick,
    output logic              spawn,
    output logic [3:0]        spawn_notes,
    output logic [1:0]        song_id,
    output logic              playing,
    output logic              done
);
    localparam int RW = $clog2(TICKS_PER_ROW + 1);
    localparam int DW = $clog2(DRAIN_TICKS_P + 2);
    localparam int LW = $clog2(ROM_LAT + 2);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [1:0]        song_id_q, song_id_d;
    logic [3:0]        sel_row_q, sel_row_d;
    logic [3:0]        notes_q, notes_d;
    logic              tick_q, tick_d;
    logic              spawn_q, spawn_d;
    logic [LW-1:0]     load_q, load_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              draining_q, draining_d;

    logic adv, wrap, row_wrap, last_row, drain_end, go_done;

    function automatic logic [ADDR_W-1:0] last_addr(input logic [1:0] id);
        case (id)
            2'd0:    last_addr = ADDR_W'(SONG_LEN_0 - 1);
            2'd1:    last_addr = ADDR_W'(SONG_LEN_1 - 1);
            2'd2:    last_addr = ADDR_W'(SONG_LEN_2 - 1);
            default: last_addr = ADDR_W'(SONG_LEN_3 - 1);
        endcase
    endfunction

    // A start or pause strobe freezes this cycle's count so resume is exact.
    assign adv = (state_q == ST_PLAY) && !start && !pause;

    chart_sequencer_tick_divider #(
        .FALL_DIV (FALL_DIV)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start),
        .en_i   (adv),
        .wrap_o (wrap)
    );

    assign row_wrap  = wrap && !draining_q && (row_q == RW'(TICKS_PER_ROW - 1));
    assign last_row  = (rom_addr_q == last_addr(song_id_q)) || (&rom_addr_q);
    assign drain_end = wrap && draining_q && (drain_q == DW'(DRAIN_TICKS_P - 1));
    assign go_done   = drain_end || (row_wrap && last_row && (DRAIN_TICKS_P == 0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD:  if (load_q == LW'(ROM_LAT)) state_d = ST_PLAY;
                ST_PLAY:  if (pause) state_d = ST_PAUSE;
                          else if (go_done) state_d = ST_DONE;
                ST_PAUSE: if (pause) state_d = ST_PLAY;
                default:  ;
            endcase
        end
    end

    always_comb begin
        playing = state_q inside {ST_LOAD, ST_PLAY, ST_PAUSE};
        done    = (state_q == ST_DONE);
    end

    always_comb begin
        case (song_id_q)
            2'd0:    sel_row_d = rom_data0;
            2'd1:    sel_row_d = rom_data1;
            2'd2:    sel_row_d = rom_data2;
            default: sel_row_d = rom_data3;
        endcase
        tick_d     = wrap;
        spawn_d    = row_wrap;
        rom_addr_d = rom_addr_q;
        song_id_d  = song_id_q;
        notes_d    = notes_q;
        load_d     = load_q;
        row_d      = row_q;
        drain_d    = drain_q;
        draining_d = draining_q;
        if (start) begin
            song_id_d  = sw;
            rom_addr_d = '0;
            load_d     = '0;
            row_d      = '0;
            drain_d    = '0;
            draining_d = 1'b0;
        end else begin
            if (state_q == ST_LOAD) begin
                load_d = load_q + 1'b1;
            end
            // The final row holds the address so the chart never wraps to row 0.
            if (row_wrap) begin
                row_d   = '0;
                notes_d = sel_row_q;
                if (last_row) begin
                    draining_d = 1'b1;
                end else begin
                    rom_addr_d = rom_addr_q + 1'b1;
                end
            end else if (wrap && draining_q) begin
                drain_d = drain_q + 1'b1;
            end else if (wrap) begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
            song_id_q  <= '0;
            sel_row_q  <= '0;
            notes_q    <= '0;
            tick_q     <= 1'b0;
            spawn_q    <= 1'b0;
            load_q     <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            draining_q <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            song_id_q  <= song_id_d;
            sel_row_q  <= sel_row_d;
            notes_q    <= notes_d;
            tick_q     <= tick_d;
            spawn_q    <= spawn_d;
            load_q     <= load_d;
            row_q      <= row_d;
            drain_q    <= drain_d;
            draining_q <= draining_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign fall_tick   = tick_q;
    assign spawn       = spawn_q;
    assign spawn_notes = notes_q;
    assign song_id     = song_id_q;

endmodule
